mc_control_unit: RTL and testbench

//  Multicycle ARM-subset control unit. Drives the shared-memory datapath (IR, PC, ALU, regfile).
//  A Moore FSM sequences each instruction. A parametrised ALU decoder maps DP Funct to ALUControl.

---
 rtl/mc_control_unit_if.sv | 33 +++
 rtl/mc_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_mc_control_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_if.sv
// Control-unit bundle: instruction fields in from the datapath, control strobes and mux selects out.
interface mc_ctrl_if #(parameter int ALU_CTRL_W = 3);
   logic [1:0]            Op;
   logic [5:0]            Funct;
   logic [3:0]            Rd;
   logic                  IRWrite;
   logic                  NextPC;
   logic                  AdrSrc;
   logic [1:0]            ResultSrc;
   logic                  ALUSrcA;
   logic [1:0]            ALUSrcB;
   logic [1:0]            ImmSrc;
   logic [1:0]            RegSrc;
   logic [ALU_CTRL_W-1:0] ALUControl;
   logic [1:0]            FlagW;
   logic                  RegW;
   logic                  MemW;
   logic                  Branch;
   logic                  PCS;
   logic                  illegal;

   modport master (
      output Op, Funct, Rd,
      input  IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
             ALUControl, FlagW, RegW, MemW, Branch, PCS, illegal
   );

   modport slave (
      input  Op, Funct, Rd,
      output IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
             ALUControl, FlagW, RegW, MemW, Branch, PCS, illegal
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle ARM-subset control unit: Moore FSM sequencer, ALU decoder and memory wait-state counter.
module mc_control_unit #(
   parameter int ALU_CTRL_W = 3,
   parameter int MEM_WAIT   = 0
) (
   input logic      clk,
   input logic      reset,
   mc_ctrl_if.slave bus
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMRD    = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWR    = 4'd5;
   localparam logic [3:0] EXECUTER = 4'd6;
   localparam logic [3:0] EXECUTEI = 4'd7;
   localparam logic [3:0] ALUWB    = 4'd8;
   localparam logic [3:0] BRANCH   = 4'd9;
   localparam logic [3:0] UNKNOWN  = 4'd10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   logic [3:0] state, nxt;
   logic [3:0] wcnt;
   logic       mem_last;

   logic [3:0] cmd;
   logic       s_bit;
   logic       dec_ok, is_cmp, arith;
   logic [2:0] dec_alu;
   logic [1:0] dec_flg;

   logic       alu_op;
   logic       ir_write, next_pc, reg_w, mem_w, branch, ill;
   logic       adr_src, src_a;
   logic [1:0] res_src, src_b;
   logic [2:0] alu3;
   logic [1:0] flg;
   logic [ALU_CTRL_W-1:0] alu_ctrl;

   assign mem_last = (wcnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         wcnt  <= '0;
      end else begin
         state <= nxt;
         // Counter only runs while parked in a memory state; any exit clears it.
         if ((state == MEMRD || state == MEMWR) && !mem_last)
            wcnt <= wcnt + 4'd1;
         else
            wcnt <= '0;
      end
   end

   // Data-processing decode; the outcome only matters while in EXECUTE*.
   always_comb begin
      cmd     = bus.Funct[4:1];
      s_bit   = bus.Funct[0];
      dec_ok  = 1'b1;
      is_cmp  = 1'b0;
      arith   = 1'b0;
      dec_alu = ALU_ADD;
      case (cmd)
         4'b0100: begin dec_alu = ALU_ADD; arith = 1'b1; end
         4'b0010: begin dec_alu = ALU_SUB; arith = 1'b1; end
         4'b1010: begin dec_alu = ALU_SUB; arith = 1'b1; is_cmp = 1'b1; end
         4'b0000: dec_alu = ALU_AND;
         4'b0001: dec_alu = ALU_EOR;
         4'b1100: dec_alu = ALU_ORR;
         4'b1101: dec_alu = ALU_ORR;
         default: dec_ok = 1'b0;
      endcase
      if (!dec_ok)
         dec_flg = 2'b00;
      else if (is_cmp)
         dec_flg = 2'b11;
      else
         dec_flg = {s_bit, s_bit & arith};
   end

   always_comb begin
      nxt      = FETCH;
      ir_write = 1'b0;
      next_pc  = 1'b0;
      reg_w    = 1'b0;
      mem_w    = 1'b0;
      branch   = 1'b0;
      ill      = 1'b0;
      adr_src  = 1'b0;
      src_a    = 1'b0;
      res_src  = 2'b00;
      src_b    = 2'b00;
      alu_op   = 1'b0;
      case (state)
         FETCH: begin
            src_a    = 1'b1;
            src_b    = 2'b10;
            res_src  = 2'b10;
            ir_write = 1'b1;
            next_pc  = 1'b1;
            nxt      = DECODE;
         end
         DECODE: begin
            src_a   = 1'b1;
            src_b   = 2'b10;
            res_src = 2'b10;
            case (bus.Op)
               2'b01:   nxt = MEMADR;
               2'b10:   nxt = BRANCH;
               2'b11:   nxt = UNKNOWN;
               default: nxt = bus.Funct[5] ? EXECUTEI : EXECUTER;
            endcase
         end
         MEMADR: begin
            src_b = 2'b01;
            nxt   = bus.Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            adr_src = 1'b1;
            nxt     = mem_last ? MEMWB : MEMRD;
         end
         MEMWB: begin
            res_src = 2'b01;
            reg_w   = 1'b1;
            nxt     = FETCH;
         end
         MEMWR: begin
            adr_src = 1'b1;
            mem_w   = mem_last;
            nxt     = mem_last ? FETCH : MEMWR;
         end
         EXECUTER, EXECUTEI: begin
            src_b  = (state == EXECUTEI) ? 2'b01 : 2'b00;
            alu_op = 1'b1;
            ill    = !dec_ok;
            nxt    = (is_cmp || !dec_ok) ? FETCH : ALUWB;
         end
         ALUWB: begin
            reg_w = 1'b1;
            nxt   = FETCH;
         end
         BRANCH: begin
            src_b   = 2'b01;
            res_src = 2'b10;
            branch  = 1'b1;
            nxt     = FETCH;
         end
         UNKNOWN: begin
            ill = 1'b1;
            nxt = FETCH;
         end
         default: nxt = FETCH;
      endcase
   end

   always_comb begin
      alu3     = alu_op ? dec_alu : ALU_ADD;
      flg      = alu_op ? dec_flg : 2'b00;
      alu_ctrl = '0;
      alu_ctrl[2:0] = alu3;
   end

   // Strobes are forced low during reset so a reset mid-instruction never leaks a write.
   assign bus.IRWrite    = ir_write & ~reset;
   assign bus.NextPC     = next_pc  & ~reset;
   assign bus.RegW       = reg_w    & ~reset;
   assign bus.MemW       = mem_w    & ~reset;
   assign bus.Branch     = branch   & ~reset;
   assign bus.PCS        = ((bus.Rd == 4'd15 & reg_w) | branch) & ~reset;
   assign bus.illegal    = ill      & ~reset;
   assign bus.AdrSrc     = adr_src;
   assign bus.ResultSrc  = res_src;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
   assign bus.ALUControl = alu_ctrl;
   assign bus.FlagW      = flg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed per-cycle vector bench for mc_control_unit (MEM_WAIT=2), plus reset-during-store sequence.
module tb_mc_control_unit;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mc_ctrl_if #(.ALU_CTRL_W(AW)) bus ();
   mc_control_unit #(.ALU_CTRL_W(AW), .MEM_WAIT(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      logic [6:0] strb;   // IRWrite NextPC RegW MemW Branch PCS illegal
      logic [5:0] mux;    // AdrSrc ResultSrc[1:0] ALUSrcA ALUSrcB[1:0]
      logic [2:0] alu;
      logic [1:0] flg;
   } vec_t;

   vec_t tbl[$];

   localparam logic [6:0] SF = 7'b1100000, S0 = 7'b0000000, SW = 7'b0010000,
                          SWP = 7'b0010010, SM = 7'b0001000, SB = 7'b0000110, SI = 7'b0000001;
   localparam logic [5:0] MFD = 6'b010110, MMA = 6'b000001, MMEM = 6'b100000,
                          MMWB = 6'b001000, MER = 6'b000000, MEI = 6'b000001, MBR = 6'b010001;

   function automatic logic [6:0] strobes();
      return {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.PCS, bus.illegal};
   endfunction

   function automatic logic [5:0] muxes();
      return {bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB};
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %b, expected %b", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                      input logic [6:0] s, input logic [5:0] m, input logic [2:0] a, input logic [1:0] f);
      vec_t v;
      v = '{op: op, funct: fn, rd: rd, strb: s, mux: m, alu: a, flg: f};
      tbl.push_back(v);
   endtask

   task automatic fd(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
      add(op, fn, rd, SF, MFD, 3'b000, 2'b00);
      add(op, fn, rd, S0, MFD, 3'b000, 2'b00);
   endtask

   initial begin
      // ADD r1
      fd(2'b00, 6'b001000, 4'd1);
      add(2'b00, 6'b001000, 4'd1, S0, MER, 3'b000, 2'b00);
      add(2'b00, 6'b001000, 4'd1, SW, MER, 3'b000, 2'b00);
      // SUBS imm
      fd(2'b00, 6'b100101, 4'd2);
      add(2'b00, 6'b100101, 4'd2, S0, MEI, 3'b001, 2'b11);
      add(2'b00, 6'b100101, 4'd2, SW, MER, 3'b000, 2'b00);
      // EORS reg
      fd(2'b00, 6'b000011, 4'd3);
      add(2'b00, 6'b000011, 4'd3, S0, MER, 3'b100, 2'b10);
      add(2'b00, 6'b000011, 4'd3, SW, MER, 3'b000, 2'b00);
      // CMP with S=0: flags still written, no writeback
      fd(2'b00, 6'b010100, 4'd4);
      add(2'b00, 6'b010100, 4'd4, S0, MER, 3'b001, 2'b11);
      // ORR reg
      fd(2'b00, 6'b011000, 4'd5);
      add(2'b00, 6'b011000, 4'd5, S0, MER, 3'b011, 2'b00);
      add(2'b00, 6'b011000, 4'd5, SW, MER, 3'b000, 2'b00);
      // ANDS imm
      fd(2'b00, 6'b100001, 4'd6);
      add(2'b00, 6'b100001, 4'd6, S0, MEI, 3'b010, 2'b10);
      add(2'b00, 6'b100001, 4'd6, SW, MER, 3'b000, 2'b00);
      // unlisted cmd 0111: illegal pulse, back to FETCH
      fd(2'b00, 6'b001111, 4'd7);
      add(2'b00, 6'b001111, 4'd7, SI, MER, 3'b000, 2'b00);
      // ADD r15: PCS follows RegW
      fd(2'b00, 6'b001000, 4'd15);
      add(2'b00, 6'b001000, 4'd15, S0, MER, 3'b000, 2'b00);
      add(2'b00, 6'b001000, 4'd15, SWP, MER, 3'b000, 2'b00);
      // LDR r15, three MEMRD cycles
      fd(2'b01, 6'b011001, 4'd15);
      add(2'b01, 6'b011001, 4'd15, S0, MMA, 3'b000, 2'b00);
      for (int k = 0; k < 3; k++) add(2'b01, 6'b011001, 4'd15, S0, MMEM, 3'b000, 2'b00);
      add(2'b01, 6'b011001, 4'd15, SWP, MMWB, 3'b000, 2'b00);
      // STR r3, MemW only on 3rd MEMWR cycle
      fd(2'b01, 6'b011000, 4'd3);
      add(2'b01, 6'b011000, 4'd3, S0, MMA, 3'b000, 2'b00);
      add(2'b01, 6'b011000, 4'd3, S0, MMEM, 3'b000, 2'b00);
      add(2'b01, 6'b011000, 4'd3, S0, MMEM, 3'b000, 2'b00);
      add(2'b01, 6'b011000, 4'd3, SM, MMEM, 3'b000, 2'b00);
      // B
      fd(2'b10, 6'b000000, 4'd0);
      add(2'b10, 6'b000000, 4'd0, SB, MBR, 3'b000, 2'b00);
      // Op=11
      fd(2'b11, 6'b000000, 4'd0);
      add(2'b11, 6'b000000, 4'd0, SI, MER, 3'b000, 2'b00);

      reset = 1'b1;
      bus.Op = 2'b00; bus.Funct = 6'b000000; bus.Rd = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_strobes", 0, {1'b0, strobes()}, 8'h00);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         bus.Op = tbl[i].op; bus.Funct = tbl[i].funct; bus.Rd = tbl[i].rd;
         #1;
         chk("strobes", i, {1'b0, strobes()}, {1'b0, tbl[i].strb});
         chk("muxes", i, {2'b0, muxes()}, {2'b0, tbl[i].mux});
         chk("alu_ctrl", i, {5'b0, bus.ALUControl}, {5'b0, tbl[i].alu});
         chk("flagw", i, {6'b0, bus.FlagW}, {6'b0, tbl[i].flg});
         @(negedge clk);
      end

      // Reset asserted in the first MEMWR cycle of a store
      bus.Op = 2'b01; bus.Funct = 6'b000000; bus.Rd = 4'd3;
      #1 chk("seq_fetch", 0, {7'b0, bus.IRWrite}, 8'd1);
      @(negedge clk);
      #1 chk("immsrc_ld", 0, {6'b0, bus.ImmSrc}, 8'd1);
      chk("regsrc_ld", 0, {6'b0, bus.RegSrc}, 8'd2);
      @(negedge clk);
      @(negedge clk);
      #1 chk("mw1_memw", 0, {7'b0, bus.MemW}, 8'd0);
      reset = 1'b1;
      #1 chk("rst_strobes", 0, {1'b0, strobes()}, 8'h00);
      @(negedge clk);
      #1 chk("rst_strobes", 1, {1'b0, strobes()}, 8'h00);
      reset = 1'b0;
      #1 chk("post_rst_fetch", 0, {1'b0, strobes()}, {1'b0, SF});
      chk("post_rst_mux", 0, {2'b0, muxes()}, {2'b0, MFD});
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk("mw_memw", k, {7'b0, bus.MemW}, (k == 2) ? 8'd1 : 8'd0);
         chk("mw_adrsrc", k, {7'b0, bus.AdrSrc}, 8'd1);
      end
      @(negedge clk);
      bus.Op = 2'b10;
      #1 chk("fetch_after_str", 0, {7'b0, bus.IRWrite}, 8'd1);
      chk("regsrc_b", 0, {6'b0, bus.RegSrc}, 8'd1);
      chk("immsrc_b", 0, {6'b0, bus.ImmSrc}, 8'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
